// File: rtl/dff_bank_write_arbiter_if.sv
// Bundle between requesters and the register-bank write arbiter.
// Ports: req/wdata from requesters; grant/owner/busy/load/ld_data back.
interface dff_bank_write_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
);

   localparam int OW = $clog2(NREQ);

   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] wdata;
   logic [NREQ-1:0]       grant;
   logic [OW-1:0]         owner;
   logic                  busy;
   logic                  load;
   logic [WIDTH-1:0]      ld_data;

   modport master (
      output req,
      output wdata,
      input  grant,
      input  owner,
      input  busy,
      input  load,
      input  ld_data
   );

   modport slave (
      input  req,
      input  wdata,
      output grant,
      output owner,
      output busy,
      output load,
      output ld_data
   );

endinterface

// File: rtl/dff_bank_write_arbiter.sv
// Round-robin owner of a shared register-bank write port.
// Ports: clock, clear (sync active-low), bus (slave side of the bundle).
module dff_bank_write_arbiter #(
   parameter int NREQ     = 4,
   parameter int WIDTH    = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic clock,
   input  logic clear,
   dff_bank_write_arbiter_if.slave bus
);

   localparam int OW = $clog2(NREQ);
   localparam int HW = $clog2(MAX_HOLD + 1);

   localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
   localparam logic [HW-1:0] HOLD_ONE = HW'(1);
   localparam logic [OW-1:0] LAST    = OW'(NREQ - 1);

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      RELEASE
   } state_t;

   state_t          state;
   logic [NREQ-1:0] grant_q;
   logic [OW-1:0]   owner_q;
   logic            busy_q;
   logic [HW-1:0]   hold_q;
   logic [OW-1:0]   ptr_q;

   logic            pick_ok;
   logic [OW-1:0]   pick;
   logic [OW-1:0]   ptr_next;
   logic [NREQ-1:0] pick_onehot;
   logic            owner_req;
   logic            load;
   int              idx;

   // Cyclic scan starting at the priority pointer; first hit wins.
   always_comb begin
      pick_ok = 1'b0;
      pick    = '0;
      idx     = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         if (!pick_ok && bus.req[idx]) begin
            pick_ok = 1'b1;
            pick    = OW'(idx);
         end
      end
   end

   always_comb begin
      pick_onehot = '0;
      pick_onehot[pick] = 1'b1;
   end

   // Pointer moves just past the owner that is letting go.
   assign ptr_next = (owner_q == LAST) ? '0 : owner_q + OW'(1);

   assign owner_req = bus.req[owner_q];

   always_ff @(posedge clock) begin
      if (!clear) begin
         state   <= IDLE;
         grant_q <= '0;
         owner_q <= '0;
         busy_q  <= 1'b0;
         hold_q  <= '0;
         ptr_q   <= '0;
      end else begin
         unique case (state)
            IDLE, RELEASE: begin
               if (pick_ok) begin
                  state   <= GRANT;
                  grant_q <= pick_onehot;
                  owner_q <= pick;
                  busy_q  <= 1'b1;
                  hold_q  <= HOLD_ONE;
               end else begin
                  state   <= IDLE;
                  grant_q <= '0;
                  busy_q  <= 1'b0;
                  hold_q  <= '0;
               end
            end
            GRANT: begin
               if (!owner_req || hold_q == HOLD_MAX) begin
                  state   <= RELEASE;
                  grant_q <= '0;
                  busy_q  <= 1'b1;
                  hold_q  <= '0;
                  ptr_q   <= ptr_next;
               end else begin
                  hold_q  <= hold_q + HOLD_ONE;
               end
            end
            default: begin
               state   <= IDLE;
               grant_q <= '0;
               busy_q  <= 1'b0;
               hold_q  <= '0;
            end
         endcase
      end
   end

   // Write strobe follows the owner's live request so a dropped
   // request suppresses the write in that same cycle.
   assign load = (state == GRANT) && owner_req;

   assign bus.grant   = grant_q;
   assign bus.owner   = owner_q;
   assign bus.busy    = busy_q;
   assign bus.load    = load;
   assign bus.ld_data = load
                      ? bus.wdata[int'(owner_q)*WIDTH +: WIDTH]
                      : '0;

endmodule

// File: tb/tb_dff_bank_write_arbiter.sv
// Scoreboard bench: MAX_HOLD=4 instance (a) and MAX_HOLD=1 instance (b).
// Stimulus pushes per-cycle expectations; a negedge monitor compares.
module tb_dff_bank_write_arbiter;

   localparam int N = 4;
   localparam int W = 8;

   logic clock;
   logic clear;

   dff_bank_write_arbiter_if #(.NREQ(N), .WIDTH(W)) ia ();
   dff_bank_write_arbiter_if #(.NREQ(N), .WIDTH(W)) ib ();

   dff_bank_write_arbiter #(
      .NREQ(N), .WIDTH(W), .MAX_HOLD(4)
   ) dut_a (
      .clock(clock),
      .clear(clear),
      .bus  (ia)
   );

   dff_bank_write_arbiter #(
      .NREQ(N), .WIDTH(W), .MAX_HOLD(1)
   ) dut_b (
      .clock(clock),
      .clear(clear),
      .bus  (ib)
   );

   typedef struct packed {
      logic       sel;
      logic [3:0] g;
      logic [1:0] o;
      logic       b;
      logic       l;
      logic [7:0] d;
   } exp_t;

   exp_t q[$];
   int   tests;
   int   fails;
   int   ncyc;

   logic [N*W-1:0] wd;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [7:0] sl(input int i);
      return wd[i*W +: W];
   endfunction

   task automatic cyc(
      input logic       s,
      input logic       clr,
      input logic [3:0] r,
      input logic [3:0] g,
      input logic [1:0] o,
      input logic       b,
      input logic       l,
      input logic [7:0] d
   );
      exp_t e;
      @(posedge clock);
      #1;
      clear = clr;
      if (s) ib.req = r;
      else   ia.req = r;
      e.sel = s;
      e.g   = g;
      e.o   = o;
      e.b   = b;
      e.l   = l;
      e.d   = d;
      q.push_back(e);
   endtask

   always @(negedge clock) begin
      exp_t e;
      exp_t a;
      if (q.size() > 0) begin
         e = q.pop_front();
         ncyc++;
         a.sel = e.sel;
         if (e.sel) begin
            a.g = ib.grant;
            a.o = ib.owner;
            a.b = ib.busy;
            a.l = ib.load;
            a.d = ib.ld_data;
         end else begin
            a.g = ia.grant;
            a.o = ia.owner;
            a.b = ia.busy;
            a.l = ia.load;
            a.d = ia.ld_data;
         end
         tests++;
         if (a !== e) begin
            fails++;
            $display(
              "FAIL step%0d dut%0d: got g=%b o=%0d b=%b l=%b d=%h, want g=%b o=%0d b=%b l=%b d=%h",
              ncyc, e.sel, a.g, a.o, a.b, a.l, a.d,
              e.g, e.o, e.b, e.l, e.d);
         end
         tests++;
         if (!$onehot0(a.g)) begin
            fails++;
            $display("FAIL onehot step%0d: got grant=%b, want one-hot or zero",
                     ncyc, a.g);
         end
      end
   end

   initial begin
      tests = 0;
      fails = 0;
      ncyc  = 0;
      wd    = {8'h44, 8'hA5, 8'h22, 8'h11};
      clear = 1'b0;
      ia.req   = 4'hF;
      ia.wdata = wd;
      ib.req   = 4'h0;
      ib.wdata = wd;

      // reset held two edges with all requests up
      cyc(0, 0, 4'hF, 4'h0, 0, 0, 0, 8'h00);
      cyc(0, 1, 4'hF, 4'h0, 0, 0, 0, 8'h00);

      // round robin with wrap, 4-cycle tenures, 1 dead cycle
      for (int o = 0; o < 4; o++) begin
         for (int h = 0; h < 4; h++) begin
            cyc(0, 1, 4'hF, 4'(1 << o), 2'(o), 1, 1, sl(o));
         end
         cyc(0, 1, 4'hF, 4'h0, 2'(o), 1, 0, 8'h00);
      end
      cyc(0, 1, 4'h0, 4'h1, 0, 1, 0, 8'h00);
      cyc(0, 1, 4'h0, 4'h0, 0, 1, 0, 8'h00);
      cyc(0, 1, 4'h4, 4'h0, 0, 0, 0, 8'h00);

      // single requester 2: four writes, dead cycle, regrant
      for (int h = 0; h < 4; h++) begin
         cyc(0, 1, 4'h4, 4'h4, 2, 1, 1, 8'hA5);
      end
      cyc(0, 1, 4'h4, 4'h0, 2, 1, 0, 8'h00);
      cyc(0, 1, 4'h0, 4'h4, 2, 1, 0, 8'h00);
      cyc(0, 1, 4'h0, 4'h0, 2, 1, 0, 8'h00);
      cyc(0, 1, 4'h2, 4'h0, 2, 0, 0, 8'h00);

      // owner 1 drops in grant cycle 2 while req[3] waits
      cyc(0, 1, 4'hA, 4'h2, 1, 1, 1, 8'h22);
      cyc(0, 1, 4'h8, 4'h2, 1, 1, 0, 8'h00);
      cyc(0, 1, 4'h8, 4'h0, 1, 1, 0, 8'h00);
      cyc(0, 1, 4'h8, 4'h8, 3, 1, 1, 8'h44);
      cyc(0, 1, 4'h1, 4'h8, 3, 1, 0, 8'h00);
      cyc(0, 1, 4'h1, 4'h0, 3, 1, 0, 8'h00);
      cyc(0, 1, 4'h4, 4'h1, 0, 1, 0, 8'h00);
      cyc(0, 1, 4'h4, 4'h0, 0, 1, 0, 8'h00);

      // owner 2 granted with pointer 1, reset in its cycle 3
      cyc(0, 1, 4'h4, 4'h4, 2, 1, 1, 8'hA5);
      cyc(0, 1, 4'h4, 4'h4, 2, 1, 1, 8'hA5);
      cyc(0, 0, 4'h4, 4'h4, 2, 1, 1, 8'hA5);
      cyc(0, 1, 4'h5, 4'h0, 0, 0, 0, 8'h00);
      cyc(0, 1, 4'h0, 4'h1, 0, 1, 0, 8'h00);
      cyc(0, 1, 4'h0, 4'h0, 0, 1, 0, 8'h00);
      cyc(0, 1, 4'h0, 4'h0, 0, 0, 0, 8'h00);

      // MAX_HOLD=1 instance alternating between 0 and 1
      cyc(1, 1, 4'h3, 4'h0, 0, 0, 0, 8'h00);
      for (int k = 0; k < 3; k++) begin
         cyc(1, 1, 4'h3, 4'h1, 0, 1, 1, 8'h11);
         cyc(1, 1, 4'h3, 4'h0, 0, 1, 0, 8'h00);
         cyc(1, 1, 4'h3, 4'h2, 1, 1, 1, 8'h22);
         cyc(1, 1, 4'h3, 4'h0, 1, 1, 0, 8'h00);
      end
      cyc(1, 1, 4'h3, 4'h1, 0, 1, 1, 8'h11);
      cyc(1, 1, 4'h0, 4'h0, 0, 1, 0, 8'h00);
      cyc(1, 1, 4'h0, 4'h0, 0, 0, 0, 8'h00);

      for (int i = 0; i < 10 && q.size() > 0; i++) begin
         @(negedge clock);
      end
      #1;
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d pending, want 0", q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dff_bank_write_arbiter.md
Name: dff_bank_write_arbiter

Overview:
- Round-robin arbiter that shares the single write port of a WIDTH-bit register bank (built from dff cells) between NREQ requesters.
- Grants one requester at a time and caps each tenure at MAX_HOLD cycles.
- Drives the bank's load strobe and load data, and inserts a one-cycle turnaround between owners.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, data width of the shared register bank.
- MAX_HOLD, 4, maximum consecutive grant cycles per tenure (>=1).

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- clear  input  1  reset, synchronous, active-low; sampled on rising edge of clock.
- req  input  NREQ  per-requester write request, level-sensitive.
- wdata  input  NREQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH].
- grant  output  NREQ  one-hot grant, registered.
- owner  output  clog2(NREQ)  index of current/last granted requester, registered.
- busy  output  1  high in GRANT and RELEASE states.
- load  output  1  write strobe to register bank; bank captures ld_data on next rising edge.
- ld_data  output  WIDTH  data to register bank.

Behaviour:
- Reset: clear=0 at a rising edge -> state IDLE, grant=0, owner=0, busy=0, hold count=0, priority pointer=0. load=0 and ld_data=0 in the following cycle. clear dominates every other input, including mid-tenure.
- States: IDLE, GRANT, RELEASE.
- Arbitration (at an edge in IDLE or RELEASE, any req bit set):
  - Select the first i with req[i]=1, scanning cyclically from pointer upward.
  - Set grant=1<<i, owner=i, hold count=1, busy=1; go to GRANT.
  - Latency: req high before edge k -> grant visible after edge k.
- IDLE with req=0: stay in IDLE, all outputs low.
- GRANT, at each edge:
  - If req[owner]=0 or hold count==MAX_HOLD -> go to RELEASE: grant=0, busy stays 1, pointer=(owner+1) mod NREQ (wraps NREQ-1 -> 0).
  - Otherwise stay in GRANT and increment hold count.
- RELEASE: lasts exactly one cycle with grant=0. At the next edge, arbitrate if any req is set, else go to IDLE with busy=0.
- Grant spacing: exactly one dead cycle between consecutive tenures.
- load/ld_data (combinational from registered state):
  - load = (state==GRANT) & req[owner].
  - ld_data = wdata[owner slice] when load=1, else 0.
  - Maximum writes per tenure = MAX_HOLD.
- Requests from non-owners during GRANT are ignored. They are not latched; a requester must hold req until granted.
- Owner drops req mid-tenure: load=0 in that cycle; RELEASE at the next edge.
- MAX_HOLD=1: every tenure is a single cycle with one write.
- owner retains its last value in IDLE and RELEASE.
- Invariants: grant is one-hot or zero at all times; grant!=0 only in GRANT.

Test Plan:
- Reset: drive clear=0 for 2 edges with req=4'b1111 -> grant=0, load=0, busy=0, owner=0. Release clear; at the next edge grant=4'b0001.
- Single requester: req=4'b0100 held, wdata slice2=8'hA5, MAX_HOLD=4 -> grant=4'b0100 for 4 cycles, load=1 with ld_data=8'hA5 each cycle (4 writes), 1 cycle grant=0, then grant=4'b0100 again.
- Round-robin with wrap: req=4'b1111 held -> grant sequence 0001,0010,0100,1000,0001. Each tenure is 4 cycles, separated by 1 dead cycle.
- Early drop: owner 1 granted, req[1] cleared in grant cycle 2 while req[3]=1 -> load=0 in that cycle, RELEASE next, then grant=4'b1000 and pointer moves past 1.
- Mid-tenure reset: clear=0 during cycle 3 of owner 2's tenure -> after that edge grant=0, load=0. After clear returns high with req=4'b0101, the first grant is 4'b0001 (pointer was reset to 0).
- MAX_HOLD=1 build: req=4'b0011 held -> grant alternates 0001,0000,0010,0000,... with exactly one load per grant.
